uart_tx_fifo: RTL

Parametrised successor to the single-byte serial transmitter. Adds a TX FIFO, runtime-programmable baud divisor, configurable parity and stop bits, and a sent-frame counter. Sits on the Wishbone (pipelined, single-cycle ack) peripheral bus and drives the board UART TX pin.

---
 rtl/uart_tx_fifo.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Wishbone-attached UART transmitter with a TX FIFO, programmable divisor,
// optional parity, one or two stop bits and a sent-frame counter.
module uart_tx_fifo #(
  parameter int FRAME          = 8,
  parameter int DEPTH          = 4,
  parameter int DIV_WIDTH      = 16,
  parameter int DEFAULT_DIVIDE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        uart_tx,
  output logic        tx_empty,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_data_w,
  output logic [31:0] wb_data_r,
  input  logic        wb_we,
  input  logic        wb_stb,
  input  logic        wb_cyc,
  output logic        wb_ack,
  output logic        wb_stall
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(FRAME + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t state, state_nxt;

  logic [DIV_WIDTH-1:0] div_r, div_q, timer;
  logic [2:0]           ctrl_r;
  logic [31:0]          frame_cnt;
  logic [31:0]          rd_val;
  logic [FRAME-1:0]     mem [DEPTH];
  logic [FRAME-1:0]     head, shift;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        occ;
  logic [IW-1:0]        bit_idx;
  logic                 par_en_q, two_stop_q, par_bit;
  logic                 full, empty, busy, xfer, push, pop, bit_end, frame_done;
  logic [1:0]           reg_sel;
  logic                 unused_bits;

  assign unused_bits = ^{wb_addr[31:4], wb_addr[1:0], wb_data_w};

  // ---- bus side ----
  assign reg_sel  = wb_addr[3:2];
  assign full     = (occ == CW'(DEPTH));
  assign empty    = (occ == '0);
  assign busy     = (state != IDLE);
  assign tx_empty = empty && !busy;
  assign wb_stall = wb_stb && wb_we && (reg_sel == 2'd0) && full;
  assign xfer     = wb_cyc && wb_stb && !wb_stall;
  assign push     = xfer && wb_we && (reg_sel == 2'd0);
  assign pop      = (state == IDLE) && !empty;

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      2'd0: rd_val = frame_cnt;
      2'd1: begin
        rd_val[0]    = busy;
        rd_val[1]    = full;
        rd_val[2]    = empty;
        rd_val[15:8] = 8'(occ);
      end
      2'd2: rd_val[DIV_WIDTH-1:0] = div_r;
      default: rd_val[2:0] = ctrl_r;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack    <= 1'b0;
      wb_data_r <= '0;
      div_r     <= DIV_WIDTH'(DEFAULT_DIVIDE - 1);
      ctrl_r    <= '0;
    end else begin
      wb_ack    <= xfer;
      wb_data_r <= (xfer && !wb_we) ? rd_val : '0;
      if (xfer && wb_we) begin
        case (reg_sel)
          2'd2:    div_r  <= wb_data_w[DIV_WIDTH-1:0];
          2'd3:    ctrl_r <= wb_data_w[2:0];
          default: ;
        endcase
      end
    end
  end

  // ---- FIFO: no push/pop bypass, so an empty FIFO never feeds the shifter directly ----
  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wb_data_w[FRAME-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: ;
      endcase
    end
  end

  // ---- transmit FSM ----
  assign bit_end    = (timer == div_q);
  assign frame_done = bit_end && ((state == STOP1 && !two_stop_q) || state == STOP2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    uart_tx   = 1'b1;
    case (state)
      IDLE:   if (pop) state_nxt = START;
      START: begin
        uart_tx = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        uart_tx = shift[0];
        if (bit_end && bit_idx == IW'(FRAME - 1))
          state_nxt = par_en_q ? PARITY : STOP1;
      end
      PARITY: begin
        uart_tx = par_bit;
        if (bit_end) state_nxt = STOP1;
      end
      STOP1:  if (bit_end) state_nxt = two_stop_q ? STOP2 : IDLE;
      STOP2:  if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Divisor and ctrl are snapshotted at pop so mid-frame writes only hit the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= '0;
      div_q      <= '0;
      shift      <= '0;
      bit_idx    <= '0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      par_bit    <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      timer <= (state == IDLE || bit_end) ? '0 : timer + DIV_WIDTH'(1);
      if (pop) begin
        shift      <= head;
        div_q      <= div_r;
        par_en_q   <= ctrl_r[0];
        two_stop_q <= ctrl_r[2];
        par_bit    <= (^head) ^ ctrl_r[1];
        bit_idx    <= '0;
      end else if (state == DATA && bit_end) begin
        shift   <= shift >> 1;
        bit_idx <= bit_idx + IW'(1);
      end
      if (frame_done) frame_cnt <= frame_cnt + 32'd1;
    end
  end

endmodule
